shifter_inverse_seq: RTL and testbench

- Multi-cycle inverse of the 16-bit SLL/SRA/ROR shifter. Undoes a shift in the opposite direction: SRL undoes SLL, SLL undoes SRA, ROL undoes ROR.
- The 4-bit shift amount is decomposed into three base-3 digits (weights 1, 3, 9). One digit-stage is applied per clock, trit-serially.
- Sits beside the ALU shifter. Used for trap/replay restore paths and shifter self-check, where area matters more than latency.

---
 rtl/shifter_inverse_seq_if.sv | 23 ++
 rtl/shifter_inverse_seq.sv | 151 +++++++++++++++
 tb/tb_shifter_inverse_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/shifter_inverse_seq_if.sv
// Request/result bundle for the trit-serial inverse shifter.
interface shifter_inverse_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] DataIn;
    logic [3:0]       ShiftVal;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] DataOut;
    logic             Busy;
    logic             Done;
    logic             Err;

    modport master (
        output Start, DataIn, ShiftVal, Mode,
        input  DataOut, Busy, Done, Err
    );

    modport slave (
        input  Start, DataIn, ShiftVal, Mode,
        output DataOut, Busy, Done, Err
    );
endinterface

// File: rtl/shifter_inverse_seq.sv
// Multi-cycle inverse of the SLL/SRA/ROR shifter. The shift amount is split into
// base-3 digits (weights 1, 3, 9) and one digit-stage is applied per clock.
module shifter_inverse_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shifter_inverse_seq_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StD0, StD1, StD2, StDone} state_e;

    localparam logic [1:0] ModeSrl = 2'd0;
    localparam logic [1:0] ModeSll = 2'd1;
    localparam logic [1:0] ModeRol = 2'd2;
    localparam logic [1:0] ModeBad = 2'd3;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       t0_q, t0_d, t1_q, t1_d;
    logic             t2_q, t2_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             in_t2;
    logic [1:0]       in_t1, in_t0;
    logic [3:0]       rem;
    logic [3:0]       stage_amt;
    logic [WIDTH-1:0] w_shifted;

    // One stage of the inverse shift; an illegal mode leaves the word untouched.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] w,
                                                     input logic [1:0]       mode,
                                                     input logic [3:0]       amt);
        case (mode)
            ModeSrl: return w >> amt;
            ModeSll: return w << amt;
            // Shift by WIDTH yields zero, so amt=0 degenerates to pass-through.
            ModeRol: return (w << amt) | (w >> (WIDTH - 32'(amt)));
            default: return w;
        endcase
    endfunction

    // Split the incoming shift amount into digits t2 (weight 9), t1 (3), t0 (1).
    always_comb begin
        in_t2 = (bus.ShiftVal >= 4'd9);
        rem   = in_t2 ? (bus.ShiftVal - 4'd9) : bus.ShiftVal;
        case (rem)
            4'd0:    {in_t1, in_t0} = {2'd0, 2'd0};
            4'd1:    {in_t1, in_t0} = {2'd0, 2'd1};
            4'd2:    {in_t1, in_t0} = {2'd0, 2'd2};
            4'd3:    {in_t1, in_t0} = {2'd1, 2'd0};
            4'd4:    {in_t1, in_t0} = {2'd1, 2'd1};
            4'd5:    {in_t1, in_t0} = {2'd1, 2'd2};
            4'd6:    {in_t1, in_t0} = {2'd2, 2'd0};
            4'd7:    {in_t1, in_t0} = {2'd2, 2'd1};
            4'd8:    {in_t1, in_t0} = {2'd2, 2'd2};
            default: {in_t1, in_t0} = {2'd0, 2'd0};
        endcase
    end

    // Weighted shift amount for the digit owned by the current stage.
    always_comb begin
        stage_amt = 4'd0;
        case (state_q)
            StD0:    stage_amt = {2'b00, t0_q};
            StD1:    stage_amt = (t1_q == 2'd2) ? 4'd6 : ((t1_q == 2'd1) ? 4'd3 : 4'd0);
            StD2:    stage_amt = t2_q ? 4'd9 : 4'd0;
            default: stage_amt = 4'd0;
        endcase
        w_shifted = shift_stage(w_q, mode_q, stage_amt);
    end

    // Sequencer next-state and register updates.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        mode_d     = mode_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StD0;
                    w_d     = bus.DataIn;
                    mode_d  = bus.Mode;
                    t0_d    = in_t0;
                    t1_d    = in_t1;
                    t2_d    = in_t2;
                    err_d   = 1'b0;
                end
            end
            StD0: begin
                w_d     = w_shifted;
                state_d = StD1;
            end
            StD1: begin
                w_d     = w_shifted;
                state_d = StD2;
            end
            StD2: begin
                // Last stage lands directly in DataOut so it is valid in the Done cycle.
                w_d        = w_shifted;
                data_out_d = w_shifted;
                err_d      = (mode_q == ModeBad);
                state_d    = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            w_q        <= '0;
            mode_q     <= 2'd0;
            t0_q       <= 2'd0;
            t1_q       <= 2'd0;
            t2_q       <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            mode_q     <= mode_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.DataOut = data_out_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Err     = err_q;

endmodule

// File: tb/tb_shifter_inverse_seq.sv
// Directed and randomized checks of the trit-serial inverse shifter.
module tb_shifter_inverse_seq;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    shifter_inverse_seq_if #(.WIDTH(16)) bus ();

    shifter_inverse_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inverse operation from arithmetic: divide/multiply by 2**s modulo 2**16.
    function automatic logic [15:0] ref_inverse(input logic [15:0] d, input int s,
                                                input int mode);
        int unsigned v, p;
        v = d;
        p = 1 << s;
        case (mode)
            0:       return 16'(v / p);
            1:       return 16'((v * p) % 65536);
            2:       return 16'(((v * p) + (v / (65536 / p))) % 65536);
            default: return d;
        endcase
    endfunction

    // Forward shifter: 0 SLL, 1 SRA, 2 ROR.
    function automatic logic [15:0] fwd(input logic [15:0] d, input int s, input int mode);
        int unsigned v, p;
        int          sv;
        v  = d;
        p  = 1 << s;
        sv = d[15] ? int'(v) - 65536 : int'(v);
        case (mode)
            0:       return 16'((v * p) % 65536);
            1:       return 16'(sv >>> s);
            default: return 16'((v / p) + ((v * (65536 / p)) % 65536));
        endcase
    endfunction

    // Original value with the bits the forward shift destroyed cleared.
    function automatic logic [15:0] round_trip(input logic [15:0] d, input int s,
                                               input int mode);
        int unsigned v, p;
        v = d;
        p = 1 << s;
        case (mode)
            0:       return 16'(v % (65536 / p));
            1:       return 16'((v / p) * p);
            default: return d;
        endcase
    endfunction

    task automatic op(input string tag, input logic [15:0] d, input logic [3:0] sv,
                      input logic [1:0] md, input logic [15:0] exp_data, input logic exp_err,
                      input bit poke_busy, input bit poke_done);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.DataIn   = d;
        bus.ShiftVal = sv;
        bus.Mode     = md;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.Start    = 1'b0;
                bus.DataIn   = ~d;
                bus.ShiftVal = ~sv;
                bus.Mode     = md ^ 2'd1;
            end
            chk({tag, ".busy"}, 16'(bus.Busy), 16'(k <= 4));
            chk({tag, ".done"}, 16'(bus.Done), 16'(k == 4));
            if (k >= 4) begin
                chk({tag, ".data"}, bus.DataOut, exp_data);
                chk({tag, ".err"}, 16'(bus.Err), 16'(exp_err));
            end
            if (poke_busy && k == 2) bus.Start = 1'b1;
            if (poke_busy && k == 3) bus.Start = 1'b0;
            if (poke_done && k == 4) bus.Start = 1'b1;
            if (poke_done && k == 5) bus.Start = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] d, f;
        logic [3:0]  s;
        logic [1:0]  m;
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.DataIn   = 16'h0;
        bus.ShiftVal = 4'h0;
        bus.Mode     = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.data", bus.DataOut, 16'h0);
        chk("rst.busy", 16'(bus.Busy), 16'h0);
        chk("rst.done", 16'(bus.Done), 16'h0);
        chk("rst.err", 16'(bus.Err), 16'h0);
        rst_n = 1'b1;

        op("srl4",   16'h8001, 4'd4,  2'd0, 16'h0800, 1'b0, 1'b0, 1'b0);
        op("sll5",   16'h0F0F, 4'd5,  2'd1, 16'hE1E0, 1'b0, 1'b0, 1'b0);
        op("rol4",   16'h1234, 4'd4,  2'd2, 16'h2341, 1'b0, 1'b0, 1'b0);
        op("rol15",  16'h8001, 4'd15, 2'd2, 16'hC000, 1'b0, 1'b0, 1'b0);
        op("zero",   16'hBEEF, 4'd0,  2'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        op("busyig", 16'hF000, 4'd8,  2'd0, 16'h00F0, 1'b0, 1'b1, 1'b0);
        op("doneig", 16'h00FF, 4'd9,  2'd1, 16'hFE00, 1'b0, 1'b0, 1'b1);
        op("srl15",  16'hFFFF, 4'd15, 2'd0, 16'h0001, 1'b0, 1'b0, 1'b0);
        op("illegal", 16'hA5C3, 4'd7, 2'd3, 16'hA5C3, 1'b1, 1'b0, 1'b0);

        // Reset in D1 discards the op and clears the sticky Err.
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.DataIn   = 16'h1234;
        bus.ShiftVal = 4'd5;
        bus.Mode     = 2'd0;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.data", bus.DataOut, 16'h0);
        chk("midrst.busy", 16'(bus.Busy), 16'h0);
        chk("midrst.done", 16'(bus.Done), 16'h0);
        chk("midrst.err", 16'(bus.Err), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst.nodone", 16'(bus.Done), 16'h0);
        end
        op("postrst", 16'h0003, 4'd1, 2'd1, 16'h0006, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            d = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 2));
            f = fwd(d, int'(s), int'(m));
            op("roundtrip", f, s, m, round_trip(d, int'(s), int'(m)), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            op("model", d, s, m, ref_inverse(d, int'(s), int'(m)), m == 2'd3, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
